// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-port arbiter: port A direct, port B via FIFO with starvation guard
// Optional WB_PEND_EN adds pending-write lookup ports q_rs1/q_rs2 -> pend_rs1/pend_rs2.
`ifndef XLEN
`define XLEN 32
`endif

module gpr_wb_arbiter #(
  parameter int XLEN       = `XLEN,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_index,
  input  logic [XLEN-1:0]          a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_index,
  input  logic [XLEN-1:0]          b_data,
  output logic                     wen,
  output logic [4:0]               index_rd,
  output logic [XLEN-1:0]          data_rd,
`ifdef WB_PEND_EN
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     pend_rs1,
  output logic                     pend_rs2,
`endif
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      mem_index [DEPTH];
  logic [XLEN-1:0] mem_data  [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [SW-1:0]   starve_cnt;

  logic            empty;
  logic            full;
  logic            push;
  logic            force_b;
  logic            grant_a;
  logic            pop;
  logic            g_valid;
  logic [4:0]      g_index;
  logic [XLEN-1:0] g_data;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pend_cnt = wr_ptr - rd_ptr;
  assign b_ready  = !full;

  // Index-0 results complete their handshake but never occupy a FIFO slot.
  assign push = b_valid && b_ready && (b_index != 5'd0);

  always_comb begin
    force_b = (starve_cnt == SW'(STARVE_MAX)) && !empty;
    a_ready = !force_b;
    grant_a = !force_b && a_valid;
    pop     = force_b || (!a_valid && !empty);
    g_valid = grant_a || pop;
    g_index = a_index;
    g_data  = a_data;
    if (pop) begin
      g_index = mem_index[rd_ptr[PW-1:0]];
      g_data  = mem_data[rd_ptr[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_index[wr_ptr[PW-1:0]] <= b_index;
      mem_data[wr_ptr[PW-1:0]]  <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop || empty)
        starve_cnt <= '0;
      else if (grant_a && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen      <= 1'b0;
      index_rd <= 5'd0;
      data_rd  <= '0;
    end else begin
      wen <= g_valid && (g_index != 5'd0);
      if (g_valid) begin
        index_rd <= g_index;
        data_rd  <= g_data;
      end
    end
  end

`ifdef WB_PEND_EN
  // A register is pending if queued in the FIFO or being written by the output stage.
  always_comb begin
    pend_rs1 = wen && (index_rd == q_rs1);
    pend_rs2 = wen && (index_rd == q_rs2);
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < pend_cnt) begin
        if (mem_index[rd_ptr[PW-1:0] + PW'(k)] == q_rs1) pend_rs1 = 1'b1;
        if (mem_index[rd_ptr[PW-1:0] + PW'(k)] == q_rs2) pend_rs2 = 1'b1;
      end
    end
    pend_rs1 = pend_rs1 && (q_rs1 != 5'd0);
    pend_rs2 = pend_rs2 && (q_rs2 != 5'd0);
  end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - directed self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_index;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_index;
  logic [XLEN-1:0] b_data;
  logic            wen;
  logic [4:0]      index_rd;
  logic [XLEN-1:0] data_rd;
  logic [2:0]      pend_cnt;
`ifdef WB_PEND_EN
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            pend_rs1;
  logic            pend_rs2;
`endif

  int vectors;
  int miscompares;

  gpr_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_index(a_index), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_index(b_index), .b_data(b_data),
    .wen(wen), .index_rd(index_rd), .data_rd(data_rd),
`ifdef WB_PEND_EN
    .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
`endif
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    a_valid = 0; a_index = 0; a_data = 0;
    b_valid = 0; b_index = 0; b_data = 0;
`ifdef WB_PEND_EN
    q_rs1 = 0; q_rs2 = 0;
`endif
    tick(); tick();
    check("rst_wen", wen, 0);
    check("rst_index", index_rd, 0);
    check("rst_data", data_rd, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_bready", b_ready, 1);
    rst = 1'b0;
    tick();

    // Fill the FIFO while A (index 0) holds every slot, then reset mid-queue.
    a_valid = 1; a_index = 0; a_data = 32'hDEAD;
    for (int i = 1; i <= 4; i++) begin
      b_valid = 1; b_index = 5'(i); b_data = 32'h100 + i;
      tick();
    end
    b_valid = 0;
    check("fill_pend", pend_cnt, 4);
    check("fill_bready", b_ready, 0);
    check("fill_wen", wen, 0);
    rst = 1'b1; a_valid = 0;
    tick();
    check("rstfull_wen", wen, 0);
    check("rstfull_pend", pend_cnt, 0);
    check("rstfull_bready", b_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_wen", wen, 0);
    end

    // Single A write.
    a_valid = 1; a_index = 5; a_data = 32'h1234;
    #1 check("a_ready", a_ready, 1);
    tick();
    check("a_wen", wen, 1);
    check("a_index", index_rd, 5);
    check("a_data", data_rd, 32'h1234);
    a_valid = 0;
    tick();
    check("a_idle_wen", wen, 0);

    // Back-to-back B with A idle: drains in order at one per cycle.
    for (int i = 1; i <= 4; i++) begin
      b_valid = 1; b_index = 5'(i); b_data = 32'hB0 + i;
      #1 check("b_ready_stream", b_ready, 1);
      tick();
      if (i == 1) check("b_first_wen", wen, 0);
      else begin
        check("b_wen", wen, 1);
        check("b_index", index_rd, 5'(i - 1));
        check("b_data", data_rd, 32'hB0 + i - 1);
      end
    end
    b_valid = 0;
    tick();
    check("b_last_index", index_rd, 4);
    check("b_last_data", data_rd, 32'hB4);
    tick();
    check("b_drained_wen", wen, 0);
    check("b_drained_pend", pend_cnt, 0);

    // Starvation guard: A continuous, one B entry queued.
    a_valid = 1; a_index = 9; a_data = 32'hA9;
    b_valid = 1; b_index = 6; b_data = 32'h66;
    #1 check("starve_c0_aready", a_ready, 1);
    tick();
    b_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      #1 check("starve_aready", a_ready, 1);
      tick();
      check("starve_a_index", index_rd, 9);
      check("starve_pend", pend_cnt, 1);
    end
    #1 check("force_aready", a_ready, 0);
    tick();
    check("force_wen", wen, 1);
    check("force_index", index_rd, 6);
    check("force_data", data_rd, 32'h66);
    #1 check("resume_aready", a_ready, 1);
    tick();
    check("resume_index", index_rd, 9);
    check("resume_pend", pend_cnt, 0);
    a_valid = 0;
    tick();

    // Index 0 on both ports: handshakes complete, nothing written or queued.
    a_valid = 1; a_index = 0; a_data = 32'h55;
    b_valid = 1; b_index = 0; b_data = 32'h77;
    #1 check("zero_aready", a_ready, 1);
    check("zero_bready", b_ready, 1);
    tick();
    check("zero_wen", wen, 0);
    check("zero_pend", pend_cnt, 0);
    a_valid = 0; b_valid = 0;
    tick();
    check("zero_wen2", wen, 0);

`ifdef WB_PEND_EN
    a_valid = 1; a_index = 0;
    b_valid = 1; b_index = 7; b_data = 32'h77;
    tick();
    b_valid = 0; q_rs1 = 7; q_rs2 = 0;
    #1 check("pend_rs1_q", pend_rs1, 1);
    check("pend_rs2_q", pend_rs2, 0);
    a_valid = 0;
    tick();
    check("pend_retire_wen", wen, 1);
    check("pend_rs1_wen", pend_rs1, 1);
    tick();
    check("pend_rs1_drop", pend_rs1, 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
